// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and hazard controller for the execute stage of a short in-order
// pipeline. It tracks which instruction occupies EXE and MEM and whether each
// one will write a register. From that it produces two things:
//   - a same-cycle stall that holds PC and IF/ID and inserts a bubble into EXE
//   - registered operand-mux selects, valid while the instruction sits in EXE
//     (0 = register file value, 1 = alu_res from MEM, 2 = wb_value from WB)
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_id_valid       ID holds a real instruction
//   i_id_src1/2      source register addresses
//   i_id_use_src1/2  instruction actually reads the source
//   i_id_wb_en       instruction writes a register
//   i_id_dest        destination register address
//   i_id_mem_r_en    instruction is a load
//   i_fwd_en         forwarding enabled (0 = resolve every hazard by stalling)
//   i_flush          branch taken, the instruction in ID is killed
//   i_freeze         global pipeline hold (memory wait)
//   o_stall          combinational stall request to IF/ID
//   o_sel_src1/2     registered EXE operand-mux selects
//   o_stall_cycles   saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [RA_W-1:0]  i_id_src1,
    input  logic [RA_W-1:0]  i_id_src2,
    input  logic             i_id_use_src1,
    input  logic             i_id_use_src2,
    input  logic             i_id_wb_en,
    input  logic [RA_W-1:0]  i_id_dest,
    input  logic             i_id_mem_r_en,
    input  logic             i_fwd_en,
    input  logic             i_flush,
    input  logic             i_freeze,
    output logic             o_stall,
    output logic [1:0]       o_sel_src1,
    output logic [1:0]       o_sel_src2,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    // In-flight scoreboard: the instruction in EXE and the one in MEM.
    logic            r_ex_v;
    logic            r_ex_wb;
    logic [RA_W-1:0] r_ex_dest;
    logic            r_ex_ld;
    logic            r_mem_v;
    logic            r_mem_wb;
    logic [RA_W-1:0] r_mem_dest;

    logic [1:0]       r_sel_src1;
    logic [1:0]       r_sel_src2;
    logic [CNT_W-1:0] r_stall_cnt;

    // Both source operands handled identically, indexed 0 = src1, 1 = src2.
    logic [RA_W-1:0] w_src [2];
    logic [1:0]      w_use;
    logic [1:0]      w_m_ex;
    logic [1:0]      w_m_mem;
    logic [1:0]      w_sel [2];

    logic w_stall_fwd;
    logic w_stall_nofwd;
    logic w_stall;
    logic w_ex_v_next;
    logic w_cnt_sat;

    assign w_src[0] = i_id_src1;
    assign w_src[1] = i_id_src2;
    assign w_use[0] = i_id_use_src1;
    assign w_use[1] = i_id_use_src2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign w_m_ex[gi]  = i_id_valid & w_use[gi] & r_ex_v & r_ex_wb
                               & (r_ex_dest == w_src[gi]);
            assign w_m_mem[gi] = i_id_valid & w_use[gi] & r_mem_v & r_mem_wb
                               & (r_mem_dest == w_src[gi]);

            // The EX producer will be in MEM next cycle and is the newer
            // value, so it takes priority over the MEM producer (then in WB).
            assign w_sel[gi] = !i_fwd_en   ? SEL_REG :
                               w_m_ex[gi]  ? SEL_MEM :
                               w_m_mem[gi] ? SEL_WB  : SEL_REG;
        end
    endgenerate

    // With forwarding only a load in EX cannot be bypassed: its data appears
    // a cycle later, so one bubble lets it reach MEM and be taken from WB.
    assign w_stall_fwd   = (|w_m_ex) & r_ex_ld;
    assign w_stall_nofwd = (|w_m_ex) | (|w_m_mem);

    // A killed instruction never creates a hazard; id_valid is already part
    // of every match term.
    assign w_stall = ~i_flush & (i_fwd_en ? w_stall_fwd : w_stall_nofwd);
    assign o_stall = w_stall;

    assign w_ex_v_next = i_id_valid & ~w_stall & ~i_flush;
    assign w_cnt_sat   = &r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_v      <= 1'b0;
            r_ex_wb     <= 1'b0;
            r_ex_dest   <= '0;
            r_ex_ld     <= 1'b0;
            r_mem_v     <= 1'b0;
            r_mem_wb    <= 1'b0;
            r_mem_dest  <= '0;
            r_sel_src1  <= SEL_REG;
            r_sel_src2  <= SEL_REG;
            r_stall_cnt <= '0;
        end else if (!i_freeze) begin
            r_mem_v    <= r_ex_v;
            r_mem_wb   <= r_ex_wb;
            r_mem_dest <= r_ex_dest;

            r_ex_v    <= w_ex_v_next;
            r_ex_wb   <= i_id_wb_en;
            r_ex_dest <= i_id_dest;
            r_ex_ld   <= i_id_mem_r_en;

            // A bubble in EXE always reads plain register values.
            r_sel_src1 <= w_ex_v_next ? w_sel[0] : SEL_REG;
            r_sel_src2 <= w_ex_v_next ? w_sel[1] : SEL_REG;

            if (w_stall && !w_cnt_sat) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_sel_src1     = r_sel_src1;
    assign o_sel_src2     = r_sel_src2;
    assign o_stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Directed scenarios for forwarding, load-use, stall-only mode, flush and
// freeze/reset, followed by a randomized run checked against a reference
// model that tracks the last two instructions issued into EXE and derives
// hazards from the distance to the nearest producer of each source.
// A narrow counter is used so that saturation is reached during the run.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    localparam int RA_W   = 4;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [RA_W-1:0] id_src1;
    logic [RA_W-1:0] id_src2;
    logic            id_use_src1;
    logic            id_use_src2;
    logic            id_wb_en;
    logic [RA_W-1:0] id_dest;
    logic            id_mem_r_en;
    logic            fwd_en;
    logic            flush;
    logic            freeze;
    logic            stall;
    logic [1:0]      sel_src1;
    logic [1:0]      sel_src2;
    logic [CW-1:0]   stall_cycles;

    int total = 0;
    int bad   = 0;

    fwd_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_valid     (id_valid),
        .i_id_src1      (id_src1),
        .i_id_src2      (id_src2),
        .i_id_use_src1  (id_use_src1),
        .i_id_use_src2  (id_use_src2),
        .i_id_wb_en     (id_wb_en),
        .i_id_dest      (id_dest),
        .i_id_mem_r_en  (id_mem_r_en),
        .i_fwd_en       (fwd_en),
        .i_flush        (flush),
        .i_freeze       (freeze),
        .o_stall        (stall),
        .o_sel_src1     (sel_src1),
        .o_sel_src2     (sel_src2),
        .o_stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic            v;
        logic            wb;
        logic [RA_W-1:0] dest;
        logic            ld;
    } ent_t;

    ent_t hist[$];      // hist[0] = newest instruction issued into EXE
    int   m_cnt;
    int   m_sel1;
    int   m_sel2;

    function automatic void model_reset();
        ent_t e;
        e = '{v: 1'b0, wb: 1'b0, dest: '0, ld: 1'b0};
        hist.delete();
        hist.push_back(e);
        hist.push_back(e);
        m_cnt  = 0;
        m_sel1 = 0;
        m_sel2 = 0;
    endfunction

    // Distance (1 = one instruction ahead, 2 = two ahead) to the nearest
    // in-flight writer of src, or 0 if none.
    function automatic int dist_of(input logic [RA_W-1:0] src, input logic use_s);
        if (!id_valid || !use_s) return 0;
        for (int d = 0; d < 2; d++) begin
            if (hist[d].v && hist[d].wb && hist[d].dest == src) return d + 1;
        end
        return 0;
    endfunction

    function automatic bit model_stall(input int d1, input int d2);
        if (flush) return 1'b0;
        if (fwd_en) return ((d1 == 1) || (d2 == 1)) && hist[0].ld;
        return (d1 != 0) || (d2 != 0);
    endfunction

    function automatic void model_edge(input int d1, input int d2, input bit st);
        ent_t e;
        bit   enter;
        if (freeze) return;
        enter  = id_valid && !st && !flush;
        m_sel1 = (enter && fwd_en) ? d1 : 0;
        m_sel2 = (enter && fwd_en) ? d2 : 0;
        e = '{v: enter, wb: id_wb_en, dest: id_dest, ld: id_mem_r_en};
        hist.push_front(e);
        void'(hist.pop_back());
        if (st && m_cnt < CNTMAX) m_cnt++;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input int s1, input int s2,
                         input logic u1, input logic u2, input logic wb,
                         input int dest, input logic ld);
        id_valid    = v;
        id_src1     = RA_W'(s1);
        id_src2     = RA_W'(s2);
        id_use_src1 = u1;
        id_use_src2 = u2;
        id_wb_en    = wb;
        id_dest     = RA_W'(dest);
        id_mem_r_en = ld;
    endtask

    task automatic clr_inputs();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        flush  = 1'b0;
        freeze = 1'b0;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic apply_reset();
        clr_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        fwd_en = 1'b1;
        rst_n  = 1'b0;
        drive(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        @(posedge clk); #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
        total++;
        if (sel_src1 !== 2'd0 || sel_src2 !== 2'd0) begin
            bad++; $display("FAIL reset_sel: got %0d/%0d want 0/0", sel_src1, sel_src2);
        end
        total++;
        if (stall_cycles !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
        @(negedge clk);
        rst_n = 1'b1;
        clr_inputs();
    endtask

    task automatic test_fwd_from_mem();
        apply_reset();
        fwd_en = 1'b1;
        drive(1'b1, 2, 3, 1'b1, 1'b1, 1'b1, 1, 1'b0);      // ADD r1,r2,r3
        @(posedge clk); @(negedge clk);
        drive(1'b1, 1, 5, 1'b1, 1'b1, 1'b1, 4, 1'b0);      // SUB r4,r1,r5
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL ex_dep_stall: got %0b want 0", stall); end
        @(posedge clk); #1;
        total++;
        if (sel_src1 !== 2'd1 || sel_src2 !== 2'd0) begin
            bad++; $display("FAIL ex_dep_sel: got %0d/%0d want 1/0", sel_src1, sel_src2);
        end
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic test_fwd_from_wb();
        apply_reset();
        fwd_en = 1'b1;
        drive(1'b1, 2, 3, 1'b1, 1'b1, 1'b1, 1, 1'b0);      // ADD r1
        @(posedge clk); @(negedge clk);
        clr_inputs();                                      // NOP
        @(posedge clk); @(negedge clk);
        drive(1'b1, 7, 1, 1'b1, 1'b1, 1'b1, 6, 1'b0);      // ORR r6,r7,r1
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL mem_dep_stall: got %0b want 0", stall); end
        @(posedge clk); #1;
        total++;
        if (sel_src1 !== 2'd0 || sel_src2 !== 2'd2) begin
            bad++; $display("FAIL mem_dep_sel: got %0d/%0d want 0/2", sel_src1, sel_src2);
        end
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic test_load_use();
        apply_reset();
        fwd_en = 1'b1;
        drive(1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 2, 1'b1);      // LDR r2,[r0]
        @(posedge clk); @(negedge clk);
        drive(1'b1, 2, 2, 1'b1, 1'b1, 1'b1, 3, 1'b0);      // ADD r3,r2,r2
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL ld_use_stall: got %0b want 1", stall); end
        @(posedge clk); #1;
        total++;
        if (stall_cycles !== CW'(1)) begin bad++; $display("FAIL ld_use_cnt1: got %0d want 1", stall_cycles); end
        @(negedge clk); #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL ld_use_release: got %0b want 0", stall); end
        @(posedge clk); #1;
        total++;
        if (sel_src1 !== 2'd2 || sel_src2 !== 2'd2) begin
            bad++; $display("FAIL ld_use_sel: got %0d/%0d want 2/2", sel_src1, sel_src2);
        end
        total++;
        if (stall_cycles !== CW'(1)) begin bad++; $display("FAIL ld_use_cnt: got %0d want 1", stall_cycles); end
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic test_stall_only();
        apply_reset();
        fwd_en = 1'b0;
        drive(1'b1, 2, 3, 1'b1, 1'b1, 1'b1, 1, 1'b0);      // ADD r1
        @(posedge clk); @(negedge clk);
        drive(1'b1, 1, 5, 1'b1, 1'b1, 1'b1, 4, 1'b0);      // SUB r4,r1,r5
        for (int c = 1; c <= 2; c++) begin
            #1;
            total++;
            if (stall !== 1'b1) begin bad++; $display("FAIL nofwd_stall%0d: got %0b want 1", c, stall); end
            @(posedge clk); #1;
            total++;
            if (stall_cycles !== CW'(c)) begin
                bad++; $display("FAIL nofwd_cnt%0d: got %0d want %0d", c, stall_cycles, c);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL nofwd_release: got %0b want 0", stall); end
        @(posedge clk); #1;
        total++;
        if (sel_src1 !== 2'd0 || sel_src2 !== 2'd0) begin
            bad++; $display("FAIL nofwd_sel: got %0d/%0d want 0/0", sel_src1, sel_src2);
        end
        @(negedge clk);
        clr_inputs();
        fwd_en = 1'b1;
    endtask

    task automatic test_flush();
        apply_reset();
        fwd_en = 1'b1;
        drive(1'b1, 2, 3, 1'b1, 1'b1, 1'b1, 1, 1'b0);      // ADD r1
        @(posedge clk); @(negedge clk);
        drive(1'b1, 1, 5, 1'b1, 1'b1, 1'b1, 4, 1'b0);      // SUB r4,r1,r5 (killed)
        flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %0b want 0", stall); end
        @(posedge clk); #1;
        total++;
        if (sel_src1 !== 2'd0 || sel_src2 !== 2'd0) begin
            bad++; $display("FAIL flush_sel: got %0d/%0d want 0/0", sel_src1, sel_src2);
        end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 4, 0, 1'b1, 1'b0, 1'b1, 6, 1'b0);      // reads r4 of the killed SUB
        @(posedge clk); #1;
        total++;
        if (sel_src1 !== 2'd0) begin bad++; $display("FAIL flush_killed_fwd: got %0d want 0", sel_src1); end
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic test_freeze_reset();
        apply_reset();
        fwd_en = 1'b1;
        drive(1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 2, 1'b1);      // LDR r2
        @(posedge clk); @(negedge clk);
        drive(1'b1, 2, 2, 1'b1, 1'b1, 1'b1, 3, 1'b0);      // ADD r3,r2,r2 (1 stall)
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        drive(1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1);      // LDR r5
        @(posedge clk); @(negedge clk);
        drive(1'b1, 5, 1, 1'b1, 1'b1, 1'b1, 6, 1'b0);      // SUB r6,r5,r1
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (stall !== 1'b1) begin bad++; $display("FAIL freeze_stall%0d: got %0b want 1", c, stall); end
            @(posedge clk); #1;
            total++;
            if (stall_cycles !== CW'(1)) begin
                bad++; $display("FAIL freeze_cnt%0d: got %0d want 1", c, stall_cycles);
            end
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;                                      // asynchronous, mid-cycle
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL midrst_stall: got %0b want 0", stall); end
        total++;
        if (sel_src1 !== 2'd0 || sel_src2 !== 2'd0) begin
            bad++; $display("FAIL midrst_sel: got %0d/%0d want 0/0", sel_src1, sel_src2);
        end
        total++;
        if (stall_cycles !== '0) begin bad++; $display("FAIL midrst_cnt: got %0d want 0", stall_cycles); end
        @(negedge clk);
        rst_n  = 1'b1;
        freeze = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL postrst_stall: got %0b want 0", stall); end
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic test_random();
        int  d1;
        int  d2;
        bit  st;
        apply_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 100 == 0) fwd_en = (n / 100) % 2 == 0;
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 9) < 3);
            flush  = $urandom_range(0, 9) == 0;
            freeze = $urandom_range(0, 6) == 0;
            d1 = dist_of(id_src1, id_use_src1);
            d2 = dist_of(id_src2, id_use_src2);
            st = model_stall(d1, d2);
            #1;
            total++;
            if (stall !== st) begin
                bad++; $display("FAIL rnd_stall n=%0d: got %0b want %0b", n, stall, st);
            end
            @(posedge clk);
            model_edge(d1, d2, st);
            #1;
            total++;
            if (sel_src1 !== 2'(m_sel1) || sel_src2 !== 2'(m_sel2)) begin
                bad++; $display("FAIL rnd_sel n=%0d: got %0d/%0d want %0d/%0d",
                                n, sel_src1, sel_src2, m_sel1, m_sel2);
            end
            total++;
            if (stall_cycles !== CW'(m_cnt)) begin
                bad++; $display("FAIL rnd_cnt n=%0d: got %0d want %0d", n, stall_cycles, m_cnt);
            end
            @(negedge clk);
        end
        total++;
        if (m_cnt != CNTMAX || stall_cycles !== CW'(CNTMAX)) begin
            bad++; $display("FAIL rnd_saturate: got %0d want %0d", stall_cycles, CNTMAX);
        end
        clr_inputs();
    endtask

    initial begin
        rst_n  = 1'b0;
        fwd_en = 1'b1;
        clr_inputs();
        test_reset();
        test_fwd_from_mem();
        test_fwd_from_wb();
        test_load_use();
        test_stall_only();
        test_flush();
        test_freeze_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
